// File: rtl/cu_pkg.sv
// Shared types for the pipelined ARM control path: opcode, condition, ALU
// encodings, flag bit positions and the control words carried down the pipe.
package cu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_e;

    typedef enum logic [3:0] {
        DP_AND = 4'b0000,
        DP_EOR = 4'b0001,
        DP_SUB = 4'b0010,
        DP_ADD = 4'b0100,
        DP_TST = 4'b1000,
        DP_CMP = 4'b1010,
        DP_ORR = 4'b1100,
        DP_MOV = 4'b1101
    } dp_cmd_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum int unsigned {
        FLAG_V = 0,
        FLAG_C = 1,
        FLAG_Z = 2,
        FLAG_N = 3
    } flag_idx_e;

    // flag_write[1] enables N/Z, flag_write[0] enables C/V
    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        alu_op_e    alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pcs;
        logic       branch;
        logic [1:0] flag_write;
    } ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pcs;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pcs;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_NOP = '0;
    localparam mem_ctrl_t MEM_NOP  = '0;
    localparam wb_ctrl_t  WB_NOP   = '0;

    // Condition-gated view of the Execute control word as it enters Memory
    function automatic mem_ctrl_t gate_to_memory(input ctrl_t c, input logic cond_ex);
        mem_ctrl_t m;
        m.reg_write  = c.reg_write & cond_ex;
        m.mem_write  = c.mem_write & cond_ex;
        m.mem_to_reg = c.mem_to_reg;
        m.pcs        = c.pcs & cond_ex;
        return m;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational main + ALU decoder: Op/Funct/Rd/Cond -> Decode-stage control word.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic [3:0] cond_i,
    input  logic [1:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [3:0] rd_i,
    output ctrl_t      ctrl_o,
    output logic [1:0] reg_src_o,
    output logic [1:0] imm_src_o
);

    logic    dp_defined;
    logic    dp_writes;
    logic    dp_arith;
    alu_op_e dp_alu;

    always_comb begin
        dp_defined = 1'b1;
        dp_writes  = 1'b1;
        dp_arith   = 1'b0;
        dp_alu     = ALU_ADD;
        case (funct_i[4:1])
            DP_ADD: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            DP_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            DP_AND: dp_alu = ALU_AND;
            DP_ORR: dp_alu = ALU_ORR;
            DP_EOR: begin dp_alu = ALU_EOR; dp_defined = (ALU_CTRL_W > 2); end
            DP_MOV: begin dp_alu = ALU_MOV; dp_defined = (ALU_CTRL_W > 2); end
            DP_CMP: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_writes = 1'b0; end
            DP_TST: begin dp_alu = ALU_AND; dp_writes = 1'b0; end
            default: dp_defined = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_o    = CTRL_NOP;
        reg_src_o = 2'b00;
        imm_src_o = 2'b00;
        case (op_i)
            OP_DP: begin
                if (dp_defined) begin
                    ctrl_o.valid     = 1'b1;
                    ctrl_o.cond      = cond_i;
                    ctrl_o.alu_op    = dp_alu;
                    ctrl_o.alu_src   = funct_i[5];
                    ctrl_o.reg_write = dp_writes;
                    // compares have no S-less form, so their flag enables are forced on
                    ctrl_o.flag_write[1] = funct_i[0] | ~dp_writes;
                    ctrl_o.flag_write[0] = dp_arith & (funct_i[0] | ~dp_writes);
                end
            end
            OP_MEM: begin
                ctrl_o.valid   = 1'b1;
                ctrl_o.cond    = cond_i;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.alu_op  = funct_i[3] ? ALU_ADD : ALU_SUB;
                imm_src_o      = 2'b01;
                if (funct_i[0]) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end else begin
                    ctrl_o.mem_write = 1'b1;
                    reg_src_o        = 2'b10;
                end
            end
            OP_BR: begin
                ctrl_o.valid   = 1'b1;
                ctrl_o.cond    = cond_i;
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.alu_op  = ALU_ADD;
                imm_src_o      = 2'b10;
                reg_src_o      = 2'b01;
            end
            default: ;
        endcase
        ctrl_o.pcs = ((rd_i == 4'd15) & ctrl_o.reg_write) | ctrl_o.branch;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined ARM control path: Decode -> Execute -> Memory -> Writeback, NZCV flags,
// condition check in Execute. Optional perf counters under CU_PERF_CNT_EN.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned FLAG_W     = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_NRESET,
    input  logic [3:0]            i_Cond,
    input  logic [1:0]            i_Op,
    input  logic [5:0]            i_Funct,
    input  logic [3:0]            i_Rd,
    input  logic [FLAG_W-1:0]     i_ALU_Flags,
    input  logic                  i_Stall_Execute,
    input  logic                  i_Flush_Execute,
    output logic [1:0]            o_Reg_Src_Decode,
    output logic [1:0]            o_Imm_Src_Decode,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control_Execute,
    output logic                  o_ALU_Src_Execute,
    output logic                  o_Mem_To_Reg_Execute,
    output logic                  o_Branch_Taken_Execute,
    output logic                  o_Reg_Write_Memory,
    output logic                  o_Mem_Write_Memory,
    output logic                  o_Reg_Write_Writeback,
    output logic                  o_Mem_To_Reg_Writeback,
    output logic                  o_PC_Src_Writeback,
    output logic                  o_PC_Write_Pending_Fetch,
    output logic [FLAG_W-1:0]     o_Flags
`ifdef CU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      o_Squash_Count,
    output logic [CNT_W-1:0]      o_Branch_Count
`endif
);

    if (ALU_CTRL_W < 2 || FLAG_W != 4 || CNT_W < 1) begin : g_bad_param
        $error("pipelined_control_unit: unsupported parameter combination");
    end

    ctrl_t            ctrl_dec;
    ctrl_t            ctrl_e_q, ctrl_e_d;
    mem_ctrl_t        mem_q, mem_d;
    wb_ctrl_t         wb_q, wb_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic             cond_true;
    logic             cond_ex;
    logic             f_n, f_z, f_c, f_v;

    cu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_decoder (
        .cond_i   (i_Cond),
        .op_i     (i_Op),
        .funct_i  (i_Funct),
        .rd_i     (i_Rd),
        .ctrl_o   (ctrl_dec),
        .reg_src_o(o_Reg_Src_Decode),
        .imm_src_o(o_Imm_Src_Decode)
    );

    assign f_n = flags_q[FLAG_N];
    assign f_z = flags_q[FLAG_Z];
    assign f_c = flags_q[FLAG_C];
    assign f_v = flags_q[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (ctrl_e_q.cond)
            COND_EQ: cond_true = f_z;
            COND_NE: cond_true = ~f_z;
            COND_CS: cond_true = f_c;
            COND_CC: cond_true = ~f_c;
            COND_MI: cond_true = f_n;
            COND_PL: cond_true = ~f_n;
            COND_VS: cond_true = f_v;
            COND_VC: cond_true = ~f_v;
            COND_HI: cond_true = f_c & ~f_z;
            COND_LS: cond_true = ~f_c | f_z;
            COND_GE: cond_true = (f_n == f_v);
            COND_LT: cond_true = (f_n != f_v);
            COND_GT: cond_true = ~f_z & (f_n == f_v);
            COND_LE: cond_true = f_z | (f_n != f_v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign cond_ex = cond_true & ctrl_e_q.valid;

    always_comb begin
        if (i_Flush_Execute) begin
            ctrl_e_d = CTRL_NOP;
        end else if (i_Stall_Execute) begin
            ctrl_e_d = ctrl_e_q;
        end else begin
            ctrl_e_d = ctrl_dec;
        end
    end

    // A stalled Execute instruction has not completed, so Memory gets a bubble
    assign mem_d = i_Stall_Execute ? MEM_NOP : gate_to_memory(ctrl_e_q, cond_ex);

    always_comb begin
        wb_d            = WB_NOP;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.mem_to_reg = mem_q.mem_to_reg;
        wb_d.pcs        = mem_q.pcs;
    end

    always_comb begin
        flags_d = flags_q;
        if (cond_ex && !i_Stall_Execute) begin
            if (ctrl_e_q.flag_write[1]) begin
                flags_d[FLAG_N] = i_ALU_Flags[FLAG_N];
                flags_d[FLAG_Z] = i_ALU_Flags[FLAG_Z];
            end
            if (ctrl_e_q.flag_write[0]) begin
                flags_d[FLAG_C] = i_ALU_Flags[FLAG_C];
                flags_d[FLAG_V] = i_ALU_Flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            ctrl_e_q <= CTRL_NOP;
            mem_q    <= MEM_NOP;
            wb_q     <= WB_NOP;
            flags_q  <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            flags_q  <= flags_d;
        end
    end

`ifdef CU_PERF_CNT_EN
    logic [CNT_W-1:0] squash_q, squash_d;
    logic [CNT_W-1:0] branch_q, branch_d;

    always_comb begin
        squash_d = squash_q;
        branch_d = branch_q;
        if (!i_Stall_Execute) begin
            if (ctrl_e_q.valid && !cond_true) begin
                squash_d = squash_q + CNT_W'(1);
            end
            if (ctrl_e_q.branch && cond_ex) begin
                branch_d = branch_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            squash_q <= '0;
            branch_q <= '0;
        end else begin
            squash_q <= squash_d;
            branch_q <= branch_d;
        end
    end

    assign o_Squash_Count = squash_q;
    assign o_Branch_Count = branch_q;
`endif

    assign o_ALU_Control_Execute    = ALU_CTRL_W'(ctrl_e_q.alu_op);
    assign o_ALU_Src_Execute        = ctrl_e_q.alu_src;
    assign o_Mem_To_Reg_Execute     = ctrl_e_q.mem_to_reg;
    assign o_Branch_Taken_Execute   = ctrl_e_q.branch & cond_ex;
    assign o_Reg_Write_Memory       = mem_q.reg_write;
    assign o_Mem_Write_Memory       = mem_q.mem_write;
    assign o_Reg_Write_Writeback    = wb_q.reg_write;
    assign o_Mem_To_Reg_Writeback   = wb_q.mem_to_reg;
    assign o_PC_Src_Writeback       = wb_q.pcs;
    assign o_PC_Write_Pending_Fetch = ctrl_dec.pcs | ctrl_e_q.pcs | mem_q.pcs;
    assign o_Flags                  = flags_q;

endmodule
